// File: rtl/mips_div_pkg.sv
// Shared types and constants for the minimips iterative divider.
package mips_div_pkg;

  localparam int          DIV_STEPS        = 32;
  localparam logic [31:0] DIV_BY_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} div_state_enum;

  // Conditional two's-complement negate, shared by operand abs and result fix-up.
  function automatic logic [31:0] div_neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mips_div_if.sv
// Execute-stage <-> divider handshake: operands in, stall/done/results out.
interface mips_div_if #(parameter int WIDTH = 32);
  logic             div_start;
  logic             div_signed;
  logic             div_cancel;
  logic [WIDTH-1:0] div_opa;
  logic [WIDTH-1:0] div_opb;
  logic             div_stall;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH-1:0] div_rem;

  modport master (
    output div_start, div_signed, div_cancel, div_opa, div_opb,
    input  div_stall, div_busy, div_done, div_quot, div_rem
  );

  modport slave (
    input  div_start, div_signed, div_cancel, div_opa, div_opb,
    output div_stall, div_busy, div_done, div_quot, div_rem
  );
endinterface

// File: rtl/mips_div_step.sv
// One combinational restoring-division step: trial subtract, keep if non-negative.
module mips_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  output logic             q_bit,
  output logic [WIDTH-1:0] rem_out
);

  logic [WIDTH:0] diff;

  assign diff    = rem_in - {1'b0, divisor};
  // A borrow into the top bit means the trial remainder went negative; restore.
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : rem_in[WIDTH-1:0];

endmodule

// File: rtl/mips_div.sv
// Iterative radix-2 DIV/DIVU unit for the execute stage; quotient -> LO, remainder -> HI.
// MIPS_DIV_SIGNED_EN enables signed (DIV) handling; otherwise every division is unsigned.
module mips_div
  import mips_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     cpu_clk_50M,
  input  logic     cpu_rst,
  mips_div_if.slave div_bus
);

  localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

  div_state_enum state, state_nxt;

  logic [WIDTH-1:0] dq;       // dividend, shifted out MSB-first as quotient bits shift in
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic [5:0]       cnt;

  logic             step_q;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] opa_abs, opb_abs;
  logic [WIDTH-1:0] quot_fin, rem_fin;

  mips_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  ({prem, dq[WIDTH-1]}),
    .divisor (dvs),
    .q_bit   (step_q),
    .rem_out (step_rem)
  );

`ifdef MIPS_DIV_SIGNED_EN
  logic sgn, q_neg, r_neg;

  assign opa_abs  = div_neg_if(dq,  sgn & dq[WIDTH-1]);
  assign opb_abs  = div_neg_if(dvs, sgn & dvs[WIDTH-1]);
  assign quot_fin = div_neg_if({dq[WIDTH-2:0], step_q}, q_neg);
  assign rem_fin  = div_neg_if(step_rem, r_neg);
`else
  assign opa_abs  = dq;
  assign opb_abs  = dvs;
  assign quot_fin = {dq[WIDTH-2:0], step_q};
  assign rem_fin  = step_rem;
`endif

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (div_bus.div_start && !div_bus.div_cancel) state_nxt = PREP;
      PREP: begin
        if (div_bus.div_cancel) state_nxt = IDLE;
        else if (dvs == '0)     state_nxt = DONE;
        else                    state_nxt = CALC;
      end
      CALC: begin
        if (div_bus.div_cancel)      state_nxt = IDLE;
        else if (cnt == LAST_STEP)   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign div_bus.div_stall = (state == IDLE && div_bus.div_start && !div_bus.div_cancel) ||
                             state == PREP || state == CALC;
  assign div_bus.div_busy  = (state != IDLE);
  assign div_bus.div_done  = (state == DONE);

  // Results are registered on the edge entering DONE so they are valid alongside div_done.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      dq               <= '0;
      dvs              <= '0;
      prem             <= '0;
      cnt              <= '0;
      div_bus.div_quot <= '0;
      div_bus.div_rem  <= '0;
`ifdef MIPS_DIV_SIGNED_EN
      sgn              <= 1'b0;
      q_neg            <= 1'b0;
      r_neg            <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (div_bus.div_start && !div_bus.div_cancel) begin
          dq  <= div_bus.div_opa;
          dvs <= div_bus.div_opb;
`ifdef MIPS_DIV_SIGNED_EN
          sgn <= div_bus.div_signed;
`endif
        end
        PREP: begin
          dq   <= opa_abs;
          dvs  <= opb_abs;
          prem <= '0;
          cnt  <= '0;
`ifdef MIPS_DIV_SIGNED_EN
          q_neg <= sgn & (dq[WIDTH-1] ^ dvs[WIDTH-1]);
          r_neg <= sgn & dq[WIDTH-1];
`endif
          if (!div_bus.div_cancel && dvs == '0) begin
            div_bus.div_quot <= DIV_BY_ZERO_QUOT;
            div_bus.div_rem  <= dq;
          end
        end
        CALC: begin
          prem <= step_rem;
          dq   <= {dq[WIDTH-2:0], step_q};
          cnt  <= cnt + 6'd1;
          if (!div_bus.div_cancel && cnt == LAST_STEP) begin
            div_bus.div_quot <= quot_fin;
            div_bus.div_rem  <= rem_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div.sv
// Randomized + directed bench for mips_div against an arithmetic reference model.
module tb_mips_div;

`ifdef MIPS_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic cpu_clk_50M = 1'b0;
  logic cpu_rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] last_q, last_r;

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  mips_div_if #(.WIDTH(32)) bus ();

  mips_div #(.WIDTH(32)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .div_bus     (bus.slave)
  );

  // Reference: plain integer division in 64-bit arithmetic (truncating toward zero).
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (SIGNED_EN && sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic next_cycle();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  // Starts a division in the next cycle (cycle 0) and follows it to div_done.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [31:0] q, output logic [31:0] r,
                        output int dc, output int stall_err);
    stall_err = 0;
    dc = -1;
    q = 'x;
    r = 'x;
    next_cycle();
    bus.div_opa = a;
    bus.div_opb = b;
    bus.div_signed = sgn;
    bus.div_start = 1'b1;
    #1;
    if (bus.div_stall !== 1'b1 || bus.div_done !== 1'b0) stall_err++;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      next_cycle();
      bus.div_start = 1'b0;
      #1;
      if (bus.div_done === 1'b1) begin
        dc = c;
        q  = bus.div_quot;
        r  = bus.div_rem;
        if (bus.div_stall !== 1'b0) stall_err++;
      end else if (bus.div_stall !== 1'b1) stall_err++;
    end
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1;
    bus.div_start = 1'b0;
    bus.div_cancel = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_opa = '0;
    bus.div_opb = '0;
    repeat (3) next_cycle();
    vectors++;
    if ({bus.div_stall, bus.div_busy, bus.div_done, bus.div_quot, bus.div_rem} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_state: got stall=%b busy=%b done=%b q=%h r=%h, want all 0",
               bus.div_stall, bus.div_busy, bus.div_done, bus.div_quot, bus.div_rem);
    end
    cpu_rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r;
    int dc, se;
    do_div(32'd100, 32'd7, 1'b0, q, r, dc, se);
    vectors++;
    if (dc !== 34 || se !== 0 || q !== 32'd14 || r !== 32'd2) begin
      miscompares++;
      $display("FAIL unsigned_100_7: got cyc=%0d stall_err=%0d q=%0d r=%0d, want cyc=34 0 q=14 r=2",
               dc, se, q, r);
    end
    last_q = 32'd14;
    last_r = 32'd2;
  endtask

  task automatic test_signed();
    logic [31:0] q, r, eq, er;
    int dc, se;
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, dc, se);
    eq = SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC;
    er = SIGNED_EN ? 32'hFFFF_FFFF : 32'd1;
    vectors++;
    if (dc !== 34 || q !== eq || r !== er) begin
      miscompares++;
      $display("FAIL neg_dividend: got cyc=%0d q=%h r=%h, want cyc=34 q=%h r=%h", dc, q, r, eq, er);
    end
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, dc, se);
    eq = SIGNED_EN ? 32'h8000_0000 : 32'd0;
    er = SIGNED_EN ? 32'd0 : 32'h8000_0000;
    vectors++;
    if (dc !== 34 || q !== eq || r !== er) begin
      miscompares++;
      $display("FAIL overflow: got cyc=%0d q=%h r=%h, want cyc=34 q=%h r=%h", dc, q, r, eq, er);
    end
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, q, r, dc, se);
    model(32'd7, 32'hFFFF_FFFE, 1'b1, eq, er);
    vectors++;
    if (dc !== 34 || q !== eq || r !== er) begin
      miscompares++;
      $display("FAIL neg_divisor: got q=%h r=%h, want q=%h r=%h", q, r, eq, er);
    end
    last_q = eq;
    last_r = er;
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r;
    int dc, se;
    do_div(32'h1234_5678, 32'd0, 1'b0, q, r, dc, se);
    vectors++;
    if (dc !== 2 || se !== 0 || q !== 32'hFFFF_FFFF || r !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL div_zero: got cyc=%0d stall_err=%0d q=%h r=%h, want cyc=2 0 q=ffffffff r=12345678",
               dc, se, q, r);
    end
    do_div(32'hFFFF_FFF9, 32'd0, 1'b1, q, r, dc, se);
    vectors++;
    if (dc !== 2 || q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFF9) begin
      miscompares++;
      $display("FAIL div_zero_signed: got cyc=%0d q=%h r=%h, want cyc=2 q=ffffffff r=fffffff9", dc, q, r);
    end
    last_q = 32'hFFFF_FFFF;
    last_r = 32'hFFFF_FFF9;
  endtask

  task automatic test_cancel();
    int seen_done;
    next_cycle();
    bus.div_opa = 32'd5000;
    bus.div_opb = 32'd3;
    bus.div_signed = 1'b0;
    bus.div_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      bus.div_start = 1'b0;
      if (c == 10) bus.div_cancel = 1'b1;
    end
    next_cycle();
    bus.div_cancel = 1'b0;
    #1;
    vectors++;
    if (bus.div_busy !== 1'b0 || bus.div_stall !== 1'b0 || bus.div_quot !== last_q ||
        bus.div_rem !== last_r) begin
      miscompares++;
      $display("FAIL cancel: got busy=%b stall=%b q=%h r=%h, want busy=0 stall=0 q=%h r=%h",
               bus.div_busy, bus.div_stall, bus.div_quot, bus.div_rem, last_q, last_r);
    end
    seen_done = 0;
    repeat (40) begin
      next_cycle();
      if (bus.div_done === 1'b1) seen_done++;
    end
    vectors++;
    if (seen_done !== 0) begin
      miscompares++;
      $display("FAIL cancel_no_done: got %0d done pulses, want 0", seen_done);
    end
    // Start and cancel together in IDLE: start is dropped.
    bus.div_start = 1'b1;
    bus.div_cancel = 1'b1;
    #1;
    vectors++;
    if (bus.div_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL start_cancel_stall: got %b want 0", bus.div_stall);
    end
    next_cycle();
    bus.div_start = 1'b0;
    bus.div_cancel = 1'b0;
    #1;
    vectors++;
    if (bus.div_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_cancel_busy: got %b want 0", bus.div_busy);
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    bus.div_opa = 32'hDEAD_BEEF;
    bus.div_opb = 32'd9;
    bus.div_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      bus.div_start = 1'b0;
      if (c == 10) cpu_rst = 1'b1;
    end
    next_cycle();
    cpu_rst = 1'b0;
    #1;
    vectors++;
    if ({bus.div_stall, bus.div_busy, bus.div_done, bus.div_quot, bus.div_rem} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got stall=%b busy=%b done=%b q=%h r=%h, want all 0",
               bus.div_stall, bus.div_busy, bus.div_done, bus.div_quot, bus.div_rem);
    end
  endtask

  task automatic test_start_ignored();
    int dc;
    logic [31:0] q, r;
    dc = -1;
    next_cycle();
    bus.div_opa = 32'd1000;
    bus.div_opb = 32'd10;
    bus.div_signed = 1'b0;
    bus.div_start = 1'b1;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      next_cycle();
      bus.div_start = (c == 5);
      if (c == 5) begin
        bus.div_opa = 32'd77;
        bus.div_opb = 32'd0;
      end
      #1;
      if (bus.div_done === 1'b1) begin
        dc = c;
        q = bus.div_quot;
        r = bus.div_rem;
      end
    end
    bus.div_start = 1'b0;
    vectors++;
    if (dc !== 34 || q !== 32'd100 || r !== 32'd0) begin
      miscompares++;
      $display("FAIL start_ignored: got cyc=%0d q=%h r=%h, want cyc=34 q=64 r=0", dc, q, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r, eq, er;
    int dc, se;
    do_div(32'd999, 32'd33, 1'b0, q, r, dc, se);
    do_div(32'hFFFF_FFF0, 32'd3, 1'b1, q, r, dc, se);
    model(32'hFFFF_FFF0, 32'd3, 1'b1, eq, er);
    vectors++;
    if (dc !== 34 || se !== 0 || q !== eq || r !== er) begin
      miscompares++;
      $display("FAIL back_to_back: got cyc=%0d stall_err=%0d q=%h r=%h, want cyc=34 0 q=%h r=%h",
               dc, se, q, r, eq, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er;
    logic sgn;
    int dc, se;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 15));
        1:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      sgn = 1'($urandom_range(0, 1));
      do_div(a, b, sgn, q, r, dc, se);
      model(a, b, sgn, eq, er);
      vectors++;
      if (dc !== ((b == 32'd0) ? 2 : 34) || se !== 0 || q !== eq || r !== er) begin
        miscompares++;
        $display("FAIL random_%0d: a=%h b=%h s=%b got cyc=%0d stall_err=%0d q=%h r=%h, want q=%h r=%h",
                 i, a, b, sgn, dc, se, q, r, eq, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_cancel();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
